// File: rtl/md_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
// cond_neg works at the widest supported datapath width; callers cast in and out.
package md_pkg;

   localparam int unsigned MD_N     = 32;
   localparam int unsigned MD_W     = 2 * MD_N;
   localparam int unsigned MD_CNT_W = $clog2(MD_N);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } md_state_t;

   // Two's-complement negation when neg is set; used for |operand| and sign fix-up.
   function automatic logic [MD_W-1:0] cond_neg(input logic [MD_W-1:0] value, input logic neg);
      return neg ? (~value + MD_W'(1)) : value;
   endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// architectural HI/LO with MTHI/MTLO writes. One iteration per cycle, N+1 cycles busy.
module md_unit
   import md_pkg::*;
#(
   parameter int unsigned N = MD_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         div,
   input  logic         u,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         hi_we,
   input  logic         lo_we,
   input  logic [N-1:0] wdata,
   output logic         busy,
   output logic         done,
   output logic         dz,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);

   localparam int unsigned W2 = 2 * N;
   localparam int unsigned CW = $clog2(N);

   md_state_t     state;
   logic [CW-1:0] cnt;
   logic [W2-1:0] acc;
   logic [N-1:0]  mb;
   logic [N-1:0]  a_orig;
   logic          is_div;
   logic          neg_q;
   logic          neg_r;

   logic [N:0]    sum;
   logic [N:0]    trial;
   logic [N-1:0]  diff;
   logic [W2-1:0] step;
   logic [N-1:0]  a_abs;
   logic [N-1:0]  b_abs;
   logic [W2-1:0] prod;
   logic [N-1:0]  quo;
   logic [N-1:0]  rem;

   // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
   always_comb begin
      sum   = {1'b0, acc[W2-1:N]} + (acc[0] ? {1'b0, mb} : '0);
      trial = {acc[W2-1:N], acc[N-1]};
      diff  = N'(trial - {1'b0, mb});
      step  = {sum, acc[N-1:1]};
      if (is_div) begin
         if (trial >= {1'b0, mb}) step = {diff, acc[N-2:0], 1'b1};
         else                     step = {trial[N-1:0], acc[N-2:0], 1'b0};
      end
   end

   always_comb begin
      a_abs = N'(cond_neg(MD_W'(a), ~u & a[N-1]));
      b_abs = N'(cond_neg(MD_W'(b), ~u & b[N-1]));
      prod  = W2'(cond_neg(MD_W'(acc), neg_q));
      quo   = N'(cond_neg(MD_W'(acc[N-1:0]), neg_q));
      rem   = N'(cond_neg(MD_W'(acc[W2-1:N]), neg_r));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         mb     <= '0;
         a_orig <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         dz     <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (start) begin
                  acc    <= {{N{1'b0}}, a_abs};
                  mb     <= b_abs;
                  a_orig <= a;
                  is_div <= div;
                  neg_q  <= ~u & (a[N-1] ^ b[N-1]);
                  neg_r  <= ~u & a[N-1];
                  dz     <= div & (b == '0);
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= CALC;
               end
            end
            CALC: begin
               acc <= step;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(N - 1)) state <= FIX;
            end
            FIX: begin
               // Divide-by-zero skips sign fix: LO all ones, HI the raw dividend.
               if (dz) begin
                  lo <= '1;
                  hi <= a_orig;
               end else if (is_div) begin
                  lo <= quo;
                  hi <= rem;
               end else begin
                  {hi, lo} <= prod;
               end
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO/dz pushed at start, checked on done.
module tb_md_unit;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        div = 1'b0;
   logic        u = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        hi_we = 1'b0;
   logic        lo_we = 1'b0;
   logic [31:0] wdata = '0;
   logic        busy;
   logic        done;
   logic        dz;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int failures = 0;
   exp_t sbq[$];

   md_unit #(.N(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .div(div), .u(u),
      .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic d, input logic uu, input logic [31:0] aa,
                                  input logic [31:0] bb);
      exp_t e;
      logic [63:0] p;
      logic signed [63:0] sp;
      e.dz = 1'b0;
      if (!d) begin
         if (uu) p = {32'b0, aa} * {32'b0, bb};
         else begin
            sp = $signed({{32{aa[31]}}, aa}) * $signed({{32{bb[31]}}, bb});
            p  = sp;
         end
         e.hi = p[63:32];
         e.lo = p[31:0];
      end else if (bb == 32'h0) begin
         e.lo = 32'hFFFF_FFFF;
         e.hi = aa;
         e.dz = 1'b1;
      end else if (uu) begin
         e.lo = aa / bb;
         e.hi = aa % bb;
      end else if (aa == 32'h8000_0000 && bb == 32'hFFFF_FFFF) begin
         e.lo = 32'h8000_0000;
         e.hi = 32'h0;
      end else begin
         e.lo = $signed(aa) / $signed(bb);
         e.hi = $signed(aa) % $signed(bb);
      end
      return e;
   endfunction

   // Completion monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (sbq.size() == 0) chk("spurious_done", 64'(1), 64'(0));
         else begin
            e = sbq.pop_front();
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
            chk("dz", 64'(dz), 64'(e.dz));
         end
      end
   end

   // mode: 0 plain, 1 re-pulse start mid-op, 2 MTLO while busy, 3 MTLO on the start edge
   task automatic run_op(input logic d, input logic uu, input logic [31:0] aa,
                         input logic [31:0] bb, input int mode);
      exp_t e;
      int bc;
      bit seen;
      logic [31:0] lo_before;
      e = model(d, uu, aa, bb);
      @(negedge clk);
      start = 1'b1; div = d; u = uu; a = aa; b = bb;
      if (mode == 3) begin
         lo_we = 1'b1;
         wdata = 32'h5A5A_0F0F;
      end
      sbq.push_back(e);
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0;
      a = $urandom; b = $urandom; div = ~d; u = ~uu;
      if (mode == 3) chk("mtlo_with_start", 64'(lo), 64'(32'h5A5A_0F0F));
      chk("dz_at_start", 64'(dz), 64'(e.dz));
      bc = 0;
      seen = 1'b0;
      lo_before = lo;
      for (int i = 0; i < 100 && !seen; i++) begin
         if (busy) bc++;
         if (done) seen = 1'b1;
         else begin
            if (mode == 1 && bc == 5) begin
               start = 1'b1; a = 32'h0000_1111; b = 32'h0000_0003;
            end
            if (mode == 2 && bc == 7) begin
               lo_before = lo; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            start = 1'b0; lo_we = 1'b0;
            if (mode == 2 && bc == 7) chk("mtlo_busy_ignored", 64'(lo), 64'(lo_before));
         end
      end
      chk("done_seen", 64'(seen), 64'(1));
      chk("busy_cycles", 64'(bc), 64'(33));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
   endtask

   initial begin
      int dcnt;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_dz", 64'(dz), 64'(0));
      chk("rst_hi", 64'(hi), 64'(0));
      chk("rst_lo", 64'(lo), 64'(0));

      hi_we = 1'b1; wdata = 32'hCAFE_BABE;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi", 64'(hi), 64'(32'hCAFE_BABE));
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0123_4567;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      chk("mthi_both", 64'(hi), 64'(32'h0123_4567));
      chk("mtlo_both", 64'(lo), 64'(32'h0123_4567));

      run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 0);
      run_op(1'b1, 1'b1, 32'h0000_0007, 32'h0000_0002, 0);
      run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, 0);
      run_op(1'b1, 1'b0, 32'hF000_0001, 32'h0000_0000, 0);
      run_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1);
      run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 2);
      run_op(1'b0, 1'b1, 32'h0001_0003, 32'h0002_0005, 3);
      for (int k = 0; k < 10; k++)
         run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 0);

      // Reset mid-operation: outputs clear asynchronously and the op never completes.
      @(negedge clk);
      start = 1'b1; div = 1'b0; u = 1'b1; a = 32'h0000_0009; b = 32'h0000_0009;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(busy), 64'(0));
      chk("arst_done", 64'(done), 64'(0));
      chk("arst_hi", 64'(hi), 64'(0));
      chk("arst_lo", 64'(lo), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("no_done_after_reset", 64'(dcnt), 64'(0));
      chk("idle_after_reset", 64'(busy), 64'(0));
      chk("sb_empty", 64'(sbq.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
